// File: rtl/dbg_scan_ctrl.sv
// dbg_scan_ctrl: debug-display sequencer. It walks entries 0..DEPTH-1 of a
// selected read channel and shows each one for a dwell period (auto mode) or
// until a step edge (manual mode). A separator word follows the last entry.
// Optional macro DBG_SCAN_BREAK_EN adds a breakpoint: in auto mode the scan
// halts on one address until a step edge arrives.
module dbg_scan_ctrl #(
  parameter int          NCH      = 4,
  parameter int          DEPTH    = 32,
  parameter int          AW       = 6,
  parameter int          DW       = 32,
  parameter int          RD_LAT   = 1,
  parameter int          TICK_DIV = 4,
  parameter logic [63:0] SEP_WORD = 64'hFFFF_FFFF_FFFF_FFFF,
  localparam int         CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en_i,
`ifdef DBG_SCAN_BREAK_EN
  input  logic              brk_en_i,
  input  logic [AW-1:0]     brk_addr_i,
`endif
  input  logic [CW-1:0]     ch_sel_i,
  input  logic              mode_i,
  input  logic              step_i,
  output logic [AW-1:0]     rd_addr_o,
  input  logic [NCH*DW-1:0] rd_data_i,
  output logic [63:0]       data_o,
  output logic              valid_o,
  output logic              wrap_o,
  output logic              busy_o
);

  localparam int DCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, SHOW, SEP} state_t;

  state_t         st, st_n;
  logic [AW-1:0]  addr, addr_n;
  logic [CW-1:0]  ch_q, ch_n;
  logic [1:0]     icnt, icnt_n;
  logic [DCW-1:0] dwell, dwell_n;
  logic [63:0]    data_n;
  logic           valid_n, wrap_n;
  logic           step_q, mode_q;

  logic [CW-1:0]  ch_eff;
  logic [DW-1:0]  rd_sel;
  logic           step_rise, mode_chg, ch_chg;
  logic           auto_adv, sep_adv, show_adv;

`ifdef DBG_SCAN_BREAK_EN
  logic brk_hold, brk_hold_n;
  logic brk_hit;
  assign brk_hit = brk_en_i && (addr == brk_addr_i);
`endif

  // Out-of-range channel selects fall back to channel 0.
  assign ch_eff    = (int'(ch_sel_i) < NCH) ? ch_sel_i : '0;
  assign rd_sel    = rd_data_i[ch_q*DW +: DW];
  assign step_rise = step_i & ~step_q;
  assign mode_chg  = mode_i != mode_q;
  assign ch_chg    = ch_eff != ch_q;
  assign rd_addr_o = addr;
  assign busy_o    = st != IDLE;

  // Advance events; a mode change restarts the dwell so no tick fires that cycle.
  always_comb begin
    auto_adv = !mode_i && !mode_chg && (dwell == DCW'(TICK_DIV - 1));
    sep_adv  = mode_i ? step_rise : auto_adv;
    show_adv = sep_adv;
`ifdef DBG_SCAN_BREAK_EN
    if (!mode_i && brk_hold) show_adv = step_rise;
`endif
  end

  // Next-state and next-output logic.
  always_comb begin
    st_n    = st;
    addr_n  = addr;
    ch_n    = ch_q;
    icnt_n  = icnt;
    dwell_n = dwell;
    data_n  = data_o;
    valid_n = 1'b0;
    wrap_n  = 1'b0;
`ifdef DBG_SCAN_BREAK_EN
    brk_hold_n = brk_hold;
`endif
    // Dwell runs only while displaying in auto mode.
    if (st == SHOW || st == SEP) begin
      if (mode_chg || mode_i) dwell_n = '0;
      else                    dwell_n = dwell + 1'b1;
    end
    case (st)
      IDLE: begin
        if (en_i) begin
          st_n   = ISSUE;
          addr_n = '0;
          ch_n   = ch_eff;
          icnt_n = '0;
        end
      end
      ISSUE: begin
        if (icnt == 2'(RD_LAT)) begin
          data_n  = {16'(ch_q), 16'(addr), 32'(rd_sel)};
          valid_n = 1'b1;
          st_n    = SHOW;
          dwell_n = '0;
`ifdef DBG_SCAN_BREAK_EN
          brk_hold_n = brk_hit;
`endif
        end else begin
          icnt_n = icnt + 2'd1;
        end
      end
      SHOW: begin
        if (ch_chg || show_adv) begin
          if (!ch_chg && addr == AW'(DEPTH - 1)) begin
            st_n    = SEP;
            data_n  = SEP_WORD;
            wrap_n  = 1'b1;
            dwell_n = '0;
          end else begin
            st_n   = ISSUE;
            addr_n = ch_chg ? '0 : addr + 1'b1;
            ch_n   = ch_eff;
            icnt_n = '0;
          end
`ifdef DBG_SCAN_BREAK_EN
          brk_hold_n = 1'b0;
`endif
        end
      end
      SEP: begin
        if (ch_chg || sep_adv) begin
          st_n   = ISSUE;
          addr_n = '0;
          ch_n   = ch_eff;
          icnt_n = '0;
        end
      end
      default: st_n = IDLE;
    endcase
    // Disabling wins over everything and blanks the display.
    if (!en_i) begin
      st_n    = IDLE;
      addr_n  = '0;
      data_n  = '0;
      valid_n = 1'b0;
      wrap_n  = 1'b0;
      icnt_n  = '0;
      dwell_n = '0;
`ifdef DBG_SCAN_BREAK_EN
      brk_hold_n = 1'b0;
`endif
    end
  end

  // State and datapath registers; async reset drops any read in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st      <= IDLE;
      addr    <= '0;
      ch_q    <= '0;
      icnt    <= '0;
      dwell   <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      wrap_o  <= 1'b0;
      step_q  <= 1'b0;
      mode_q  <= 1'b0;
`ifdef DBG_SCAN_BREAK_EN
      brk_hold <= 1'b0;
`endif
    end else begin
      st      <= st_n;
      addr    <= addr_n;
      ch_q    <= ch_n;
      icnt    <= icnt_n;
      dwell   <= dwell_n;
      data_o  <= data_n;
      valid_o <= valid_n;
      wrap_o  <= wrap_n;
      step_q  <= step_i;
      mode_q  <= mode_i;
`ifdef DBG_SCAN_BREAK_EN
      brk_hold <= brk_hold_n;
`endif
    end
  end

endmodule

// File: tb/tb_dbg_scan_ctrl.sv
// Directed bench for dbg_scan_ctrl with a scoreboard of expected display words.
module tb_dbg_scan_ctrl;
  localparam int NCH = 4, DEPTH = 32, AW = 6, DW = 32, RD_LAT = 1, TICK_DIV = 4;
  localparam logic [63:0] SEP = 64'hFFFF_FFFF_FFFF_FFFF;

  logic              clk = 1'b0, rstn = 1'b0, en_i = 1'b0;
  logic [1:0]        ch_sel_i = '0;
  logic              mode_i = 1'b0, step_i = 1'b0;
  logic [AW-1:0]     rd_addr_o, addr_d = '0;
  logic [NCH*DW-1:0] rd_data_i;
  logic [63:0]       data_o;
  logic              valid_o, wrap_o, busy_o;
`ifdef DBG_SCAN_BREAK_EN
  logic              brk_en_i = 1'b0;
  logic [AW-1:0]     brk_addr_i = '0;
`endif

  typedef struct { logic sep; logic [63:0] d; } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, ev_cnt = 0, cyc = 0, prev_cyc = 0;
  bit spacing_on = 0, have_prev = 0;

  dbg_scan_ctrl #(.NCH(NCH), .DEPTH(DEPTH), .AW(AW), .DW(DW), .RD_LAT(RD_LAT),
                  .TICK_DIV(TICK_DIV), .SEP_WORD(SEP)) dut (
    .clk(clk), .rstn(rstn), .en_i(en_i),
`ifdef DBG_SCAN_BREAK_EN
    .brk_en_i(brk_en_i), .brk_addr_i(brk_addr_i),
`endif
    .ch_sel_i(ch_sel_i), .mode_i(mode_i), .step_i(step_i),
    .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i), .data_o(data_o),
    .valid_o(valid_o), .wrap_o(wrap_o), .busy_o(busy_o));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input int k, input int a);
    return 32'(a * 3 + ((k ^ 1) << 24));
  endfunction

  function automatic logic [63:0] ent(input int k, input int a);
    return {16'(k), 16'(a), mem(k, a)};
  endfunction

  // Memory model with one cycle of read latency.
  always @(posedge clk) addr_d <= rd_addr_o;
  always_comb begin
    rd_data_i = '0;
    for (int k = 0; k < NCH; k++) rd_data_i[k*DW +: DW] = mem(k, int'(addr_d));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] e_v);
    tests++;
    assert (obs === e_v) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, e_v);
    end
  endtask

  task automatic push(input logic sep, input logic [63:0] d);
    exp_t e;
    e.sep = sep; e.d = d;
    sb.push_back(e);
  endtask

  // Compare every displayed entry/separator against the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (rstn && (valid_o || wrap_o)) begin
      ev_cnt++;
      chk("unexpected_output", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("wrap", 64'(wrap_o), 64'(e.sep));
        chk("valid", 64'(valid_o), 64'(!e.sep));
        chk("data", data_o, e.d);
      end
      if (spacing_on && have_prev)
        chk("spacing", 64'(cyc - prev_cyc), wrap_o ? 64'd4 : 64'd6);
      prev_cyc  = cyc;
      have_prev = 1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_events(input int n, input int budget, input string tag);
    int b = 0;
    while (ev_cnt < n && b < budget) begin
      tick();
      b++;
    end
    chk(tag, 64'(ev_cnt >= n), 64'd1);
  endtask

  task automatic pulse();
    step_i = 1'b1; tick();
    step_i = 1'b0; tick();
  endtask

  initial begin
    int n;
    // Reset state
    #3;
    chk("rst_addr", 64'(rd_addr_o), 64'd0);
    chk("rst_data", data_o, 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_wrap", 64'(wrap_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    tick(); tick();
    rstn = 1'b1;
    tick();

    // Auto scan of channel 1: full pass, separator, back to address 0
    for (int a = 0; a < DEPTH; a++) push(1'b0, ent(1, a));
    push(1'b1, SEP);
    push(1'b0, ent(1, 0));
    spacing_on = 1; have_prev = 0;
    ch_sel_i = 2'd1; mode_i = 1'b0; en_i = 1'b1;
    wait_events(DEPTH + 2, 500, "auto_timeout");
    spacing_on = 0;
    en_i = 1'b0;
    tick();
    chk("auto_sb_empty", 64'(sb.size()), 64'd0);

    // Manual stepping, one long pulse, one edge dropped during ISSUE
    mode_i = 1'b1; ch_sel_i = 2'd0;
    push(1'b0, ent(0, 0));
    en_i = 1'b1;
    wait_events(ev_cnt + 1, 20, "man0_timeout");
    push(1'b0, ent(0, 1));
    pulse();
    wait_events(ev_cnt + 1, 20, "man1_timeout");
    push(1'b0, ent(0, 2));
    n = ev_cnt;
    step_i = 1'b1;
    repeat (10) tick();
    step_i = 1'b0;
    tick();
    chk("long_pulse_one_adv", 64'(ev_cnt - n), 64'd1);
    push(1'b0, ent(0, 3));
    n = ev_cnt;
    step_i = 1'b1; tick();
    step_i = 1'b0; tick();
    step_i = 1'b1; tick();
    step_i = 1'b0;
    repeat (20) tick();
    chk("issue_step_dropped", 64'(ev_cnt - n), 64'd1);
    chk("man_addr3", 64'(rd_addr_o), 64'd3);
    chk("man_sb_empty", 64'(sb.size()), 64'd0);

    // Channel switch while showing address 17
    for (int a = 4; a <= 17; a++) begin
      push(1'b0, ent(0, a));
      pulse();
      wait_events(ev_cnt + 1, 20, "step_timeout");
    end
    chk("show17_addr", 64'(rd_addr_o), 64'd17);
    push(1'b0, ent(2, 0));
    ch_sel_i = 2'd2;
    wait_events(ev_cnt + 1, 20, "chsw_timeout");
    chk("chsw_ch", 64'(data_o[63:48]), 64'd2);
    chk("chsw_addr", 64'(rd_addr_o), 64'd0);

    // Disable in the middle of the read of address 5
    for (int a = 1; a <= 4; a++) begin
      push(1'b0, ent(2, a));
      pulse();
      wait_events(ev_cnt + 1, 20, "step2_timeout");
    end
    n = ev_cnt;
    step_i = 1'b1; tick();
    step_i = 1'b0;
    chk("issue5_addr", 64'(rd_addr_o), 64'd5);
    en_i = 1'b0;
    tick();
    chk("dis_busy", 64'(busy_o), 64'd0);
    chk("dis_data", data_o, 64'd0);
    chk("dis_addr", 64'(rd_addr_o), 64'd0);
    repeat (10) tick();
    chk("dis_no_valid", 64'(ev_cnt - n), 64'd0);
    mode_i = 1'b0;
    push(1'b0, ent(2, 0));
    en_i = 1'b1;
    wait_events(ev_cnt + 1, 20, "reen_timeout");
    chk("reen_addr", 64'(rd_addr_o), 64'd0);

    // Asynchronous reset while showing an entry
    #2 rstn = 1'b0;
    #1;
    chk("arst_data", data_o, 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_addr", 64'(rd_addr_o), 64'd0);
    chk("arst_valid", 64'(valid_o), 64'd0);
    en_i = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    n = ev_cnt;
    repeat (10) tick();
    chk("arst_quiet", 64'(ev_cnt - n), 64'd0);

`ifdef DBG_SCAN_BREAK_EN
    // Breakpoint on address 4 in auto mode
    brk_en_i = 1'b1; brk_addr_i = 6'd4; ch_sel_i = 2'd1; mode_i = 1'b0;
    for (int a = 0; a <= 4; a++) push(1'b0, ent(1, a));
    en_i = 1'b1;
    wait_events(ev_cnt + 5, 100, "brk_run_timeout");
    n = ev_cnt;
    repeat (100) tick();
    chk("brk_hold_events", 64'(ev_cnt - n), 64'd0);
    chk("brk_hold_addr", 64'(rd_addr_o), 64'd4);
    for (int a = 5; a <= 7; a++) push(1'b0, ent(1, a));
    pulse();
    wait_events(n + 3, 40, "brk_resume_timeout");
    en_i = 1'b0;
    brk_en_i = 1'b0;
    tick();
`endif

    tick(); tick();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
